// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg
// Shared types and constants for the compressed-frame read side.
//   fsr_state_e : reader FSM states (3-bit encoding)
//   PIX_W       : output pixel width
//   BYTE_W      : frame-buffer byte width
//   pack_pixel  : joins two consecutive stream bytes into one pixel
package frame_stream_pkg;

  localparam int PIX_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DISCARD = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } fsr_state_e;

  // The first byte of a pair is the most significant half of the pixel.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [BYTE_W-1:0] hi_byte,
                                                  input logic [BYTE_W-1:0] lo_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/frame_xy_counter.sv
// frame_xy_counter
// Tracks the (x, y) position of the next pixel to be packed in a frame.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous return to (0,0); wins over step
//   step           : advance one pixel position
//   sof            : current position is (0,0)
//   eol            : current position is the last pixel of a line
//   last_pixel     : current position is the last pixel of the frame
module frame_xy_counter
  import frame_stream_pkg::*;
#(
  parameter int H_PIXELS = 240,
  parameter int V_LINES  = 240
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic step,
  output logic sof,
  output logic eol,
  output logic last_pixel
);

  // A single-line frame still needs a 1-bit y register.
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_LINES  > 1) ? $clog2(V_LINES)  : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;

  // Position register: x wraps per line, y saturates on the last line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_r <= '0;
      y_r <= '0;
    end else if (clear) begin
      x_r <= '0;
      y_r <= '0;
    end else if (step) begin
      if (x_r == X_LAST) begin
        x_r <= '0;
        if (y_r != Y_LAST) begin
          y_r <= y_r + YW'(1);
        end else begin
          y_r <= y_r;
        end
      end else begin
        x_r <= x_r + XW'(1);
        y_r <= y_r;
      end
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  assign sof        = (x_r == '0) && (y_r == '0);
  assign eol        = (x_r == X_LAST);
  assign last_pixel = (x_r == X_LAST) && (y_r == Y_LAST);

endmodule

// File: rtl/frame_stream_reader.sv
// frame_stream_reader
// Pulls one compressed frame from the frame buffer on request, packs byte
// pairs into 16-bit pixels and streams them downstream with valid/ready,
// bounding the frame to H_PIXELS x V_LINES pixels.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   inter_reset             : synchronous active-low soft reset
//   frame_trigger           : start one frame (only honoured in IDLE)
//   decompress_start        : one-cycle kick to the frame buffer
//   enc_data_req            : byte consume strobe (combinational)
//   enc_rd_data_ready/out   : frame buffer byte and its valid
//   enc_rd_data_out_finish  : pulse after the last byte was consumed
//   pix_data/valid/ready    : pixel stream, {first byte, second byte}
//   pix_sof, pix_eol        : pixel (0,0) / last pixel of a line
//   busy, frame_done        : activity and end-of-frame pulse
//   short_err, long_err     : sticky frame length errors
module frame_stream_reader
  import frame_stream_pkg::*;
#(
  parameter int H_PIXELS = 240,
  parameter int V_LINES  = 240
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              inter_reset,
  input  logic              frame_trigger,
  output logic              decompress_start,
  output logic              enc_data_req,
  input  logic              enc_rd_data_ready,
  input  logic [BYTE_W-1:0] enc_rd_data_out,
  input  logic              enc_rd_data_out_finish,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              short_err,
  output logic              long_err
);

  fsr_state_e        state_r;
  fsr_state_e        state_nx_s;

  logic              req_s;
  logic              take_s;
  logic              start_s;
  logic              set_short_s;
  logic              set_long_s;
  logic              pix_room_s;
  logic              pack_s;
  logic              accept_s;
  logic              xy_clear_s;
  logic              xy_sof_s;
  logic              xy_eol_s;
  logic              last_pixel_s;

  logic              phase_r;
  logic              complete_r;
  logic [BYTE_W-1:0] hi_byte_r;
  logic [PIX_W-1:0]  pix_data_r;
  logic              pix_valid_r;
  logic              pix_sof_r;
  logic              pix_eol_r;
  logic              decompress_start_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              short_err_r;
  logic              long_err_r;

  // A new byte may only be taken when the pixel register is free or being emptied.
  assign pix_room_s = !pix_valid_r || pix_ready;
  assign pack_s     = take_s && phase_r;
  assign accept_s   = pix_valid_r && pix_ready;
  assign xy_clear_s = start_s || !inter_reset;

  frame_xy_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES)
  ) u_xy (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (xy_clear_s),
    .step       (pack_s),
    .sof        (xy_sof_s),
    .eol        (xy_eol_s),
    .last_pixel (last_pixel_s)
  );

  // Next-state, byte request and error-set decode.
  always_comb begin
    state_nx_s  = state_r;
    req_s       = 1'b0;
    take_s      = 1'b0;
    start_s     = 1'b0;
    set_short_s = 1'b0;
    set_long_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_trigger) begin
          start_s    = 1'b1;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nx_s = ST_WAIT;
      end
      // The first byte is taken on the same cycle ready is seen, so the
      // first pixel lands two cycles after the buffer becomes ready.
      ST_WAIT: begin
        if (enc_rd_data_ready) begin
          req_s      = pix_room_s;
          take_s     = pix_room_s;
          state_nx_s = ST_STREAM;
        end else if (enc_rd_data_out_finish) begin
          set_short_s = 1'b1;
          state_nx_s  = ST_DRAIN;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      // Once the last pixel is packed, a finish in the following cycle is
      // normal completion; a byte still offered there means a long frame.
      ST_STREAM: begin
        if (complete_r) begin
          if (enc_rd_data_ready) begin
            set_long_s = 1'b1;
            if (enc_rd_data_out_finish) begin
              state_nx_s = ST_DRAIN;
            end else begin
              state_nx_s = ST_DISCARD;
            end
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end else if (enc_rd_data_out_finish) begin
          set_short_s = 1'b1;
          state_nx_s  = ST_DRAIN;
        end else begin
          req_s      = enc_rd_data_ready && pix_room_s;
          take_s     = enc_rd_data_ready && pix_room_s;
          state_nx_s = ST_STREAM;
        end
      end
      ST_DISCARD: begin
        req_s = enc_rd_data_ready;
        if (enc_rd_data_out_finish) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_DISCARD;
        end
      end
      ST_DRAIN: begin
        if (!pix_valid_r) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus the outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r            <= ST_IDLE;
      decompress_start_r <= 1'b0;
      busy_r             <= 1'b0;
      frame_done_r       <= 1'b0;
    end else if (!inter_reset) begin
      state_r            <= ST_IDLE;
      decompress_start_r <= 1'b0;
      busy_r             <= 1'b0;
      frame_done_r       <= 1'b0;
    end else begin
      state_r            <= state_nx_s;
      decompress_start_r <= (state_nx_s == ST_START);
      busy_r             <= (state_nx_s != ST_IDLE);
      frame_done_r       <= (state_nx_s == ST_DONE);
    end
  end

  // Byte phase, pending high byte, frame-complete flag and sticky errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_r     <= 1'b0;
      complete_r  <= 1'b0;
      hi_byte_r   <= {BYTE_W{1'b0}};
      short_err_r <= 1'b0;
      long_err_r  <= 1'b0;
    end else if (!inter_reset) begin
      phase_r     <= 1'b0;
      complete_r  <= 1'b0;
      hi_byte_r   <= {BYTE_W{1'b0}};
      short_err_r <= 1'b0;
      long_err_r  <= 1'b0;
    end else if (start_s) begin
      phase_r     <= 1'b0;
      complete_r  <= 1'b0;
      short_err_r <= 1'b0;
      long_err_r  <= 1'b0;
    end else begin
      if (take_s) begin
        phase_r <= ~phase_r;
        if (!phase_r) begin
          hi_byte_r <= enc_rd_data_out;
        end
      end else if (set_short_s) begin
        // A half pixel left at a short finish is simply dropped.
        phase_r <= 1'b0;
      end
      if (pack_s && last_pixel_s) begin
        complete_r <= 1'b1;
      end
      if (set_short_s) begin
        short_err_r <= 1'b1;
      end
      if (set_long_s) begin
        long_err_r <= 1'b1;
      end
    end
  end

  // Output pixel register: loads on the second byte, holds until accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_data_r  <= {PIX_W{1'b0}};
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eol_r   <= 1'b0;
    end else if (!inter_reset) begin
      pix_data_r  <= {PIX_W{1'b0}};
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eol_r   <= 1'b0;
    end else if (pack_s) begin
      pix_data_r  <= pack_pixel(hi_byte_r, enc_rd_data_out);
      pix_valid_r <= 1'b1;
      pix_sof_r   <= xy_sof_s;
      pix_eol_r   <= xy_eol_s;
    end else if (accept_s) begin
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eol_r   <= 1'b0;
    end
  end

  assign enc_data_req     = req_s;
  assign decompress_start = decompress_start_r;
  assign pix_data         = pix_data_r;
  assign pix_valid        = pix_valid_r;
  assign pix_sof          = pix_sof_r;
  assign pix_eol          = pix_eol_r;
  assign busy             = busy_r;
  assign frame_done       = frame_done_r;
  assign short_err        = short_err_r;
  assign long_err         = long_err_r;

endmodule
